// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's M-op decode and the multiply/divide unit.
interface muldiv_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, funct3, rs1_data, rs2_data,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider sharing one
// 64-bit working register; 32 iterations per op, divide special cases resolved at accept.
module muldiv_unit (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  mdu
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned WLEN = 2 * XLEN;
   localparam int unsigned CNTW = 6;
   localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

   state_t            r_state;
   logic [CNTW-1:0]   r_cnt;
   logic [WLEN-1:0]   r_work;
   logic [XLEN-1:0]   r_opb;
   logic [2:0]        r_fn;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_is_div;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_div_zero;
   logic              w_div_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_trial;
   logic [WLEN-1:0]   w_next_work;
   logic [WLEN-1:0]   w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_final;

   // Accept-time decode: signedness, magnitudes and divide special cases.
   always_comb begin
      w_is_div      = mdu.funct3[2];
      w_a_signed    = w_is_div ? !mdu.funct3[0] : (mdu.funct3[1:0] != 2'b11);
      w_b_signed    = w_is_div ? !mdu.funct3[0] : !mdu.funct3[1];
      w_a_neg       = w_a_signed & mdu.rs1_data[XLEN-1];
      w_b_neg       = w_b_signed & mdu.rs2_data[XLEN-1];
      w_a_mag       = w_a_neg ? XLEN'(-mdu.rs1_data) : mdu.rs1_data;
      w_b_mag       = w_b_neg ? XLEN'(-mdu.rs2_data) : mdu.rs2_data;
      w_div_zero    = w_is_div && (mdu.rs2_data == '0);
      w_div_ovf     = w_is_div && !mdu.funct3[0] &&
                      (mdu.rs1_data == 32'h8000_0000) && (mdu.rs2_data == 32'hFFFF_FFFF);
      w_special     = w_div_zero || w_div_ovf;
      w_special_res = '0;
      if (w_div_zero)
         w_special_res = mdu.funct3[1] ? mdu.rs1_data : '1;
      else if (w_div_ovf)
         w_special_res = mdu.funct3[1] ? '0 : 32'h8000_0000;
   end

   // One iteration step plus sign correction of the value the last step produces.
   always_comb begin
      w_sum       = {1'b0, r_work[WLEN-1:XLEN]} + (r_work[0] ? {1'b0, r_opb} : '0);
      w_trial     = r_work[WLEN-1:XLEN-1] - {1'b0, r_opb};
      w_next_work = {w_sum, r_work[XLEN-1:1]};
      if (r_fn[2]) begin
         if (w_trial[XLEN])
            w_next_work = {r_work[WLEN-2:0], 1'b0};
         else
            w_next_work = {w_trial[XLEN-1:0], r_work[XLEN-2:0], 1'b1};
      end
      w_prod  = r_neg_q ? WLEN'(-w_next_work) : w_next_work;
      w_quo   = r_neg_q ? XLEN'(-w_next_work[XLEN-1:0]) : w_next_work[XLEN-1:0];
      w_rem   = r_neg_r ? XLEN'(-w_next_work[WLEN-1:XLEN]) : w_next_work[WLEN-1:XLEN];
      w_final = '0;
      if (r_fn[2])
         w_final = r_fn[1] ? w_rem : w_quo;
      else
         w_final = (r_fn[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[WLEN-1:XLEN];
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_work   <= '0;
         r_opb    <= '0;
         r_fn     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (mdu.start) begin
                  r_fn    <= mdu.funct3;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_opb   <= w_b_mag;
                  r_work  <= {{XLEN{1'b0}}, w_a_mag};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_done   <= 1'b1;
                     r_state  <= ST_DONE;
                  end else begin
                     r_state  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_work <= w_next_work;
               r_cnt  <= r_cnt + CNTW'(1);
               if (r_cnt == LAST_ITER) begin
                  r_result <= w_final;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mdu.busy   = r_busy;
   assign mdu.done   = r_done;
   assign mdu.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mdu   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          done_cyc;
      logic [2:0]  fn;
   } exp_t;

   exp_t sb[$];
   int   done_hist[$];

   // Architectural reference: plain 64-bit arithmetic on the operand values.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa;
      longint      sbv;
      longint      ua;
      longint      ub;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      case (f)
         3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
         3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
         3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = 64'(sa / sbv); return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = 64'(ua / ub); return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = 64'(sa % sbv); return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = 64'(ua % ub); return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
      return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every done pulse against the oldest outstanding expectation.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (bus.done) begin
            done_hist.push_back(cyc);
            check("done_width", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got result %h with no outstanding op", bus.result);
            end else begin
               e = sb.pop_front();
               check($sformatf("result_f%0d", e.fn), bus.result, e.res);
               check_int($sformatf("done_cycle_f%0d", e.fn), cyc, e.done_cyc);
            end
         end
         prev_done = bus.done;
      end
   end

   // Issue one op, wait for its done pulse, then retire on the following edge.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit perturb, input bit hold);
      exp_t e;
      int   n;
      int   busy_cnt;
      bit   got;
      bit   spec;
      spec = is_special(f, a, b);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = f;
      bus.rs1_data = a;
      bus.rs2_data = b;
      @(posedge clk);
      #1;
      n          = cyc;
      e.res      = exp_res;
      e.done_cyc = n + (spec ? 0 : 32);
      e.fn       = f;
      sb.push_back(e);
      busy_cnt = 0;
      got      = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) got = 1'b1;
         else if (perturb) begin
            bus.funct3   = 3'($urandom_range(0, 7));
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done within 40 cycles, required one (f=%0d)", f);
         sb.delete();
      end
      check_int("busy_cycles", busy_cnt, spec ? 1 : 33);
      @(posedge clk);
      if (!hold) begin
         #1;
         bus.start = 1'b0;
      end
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      bus.start    = 1'b0;
      bus.funct3   = '0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      repeat (3) @(negedge clk);
      check("reset_result", bus.result, 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;

      do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 1'b0);
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b1, 1'b0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(3'd5, 32'd100,        32'd7,          32'd14,        1'b0, 1'b0);
      do_op(3'd7, 32'd100,        32'd7,          32'd2,         1'b0, 1'b0);
      do_op(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(3'd6, 32'd5,          32'd0,          32'd5,         1'b0, 1'b0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);

      // Reset in the middle of CALC: outputs clear immediately, no result appears.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = 3'd0;
      bus.rs1_data = 32'd1234;
      bus.rs2_data = 32'd5678;
      @(posedge clk);
      repeat (15) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_done", 32'(bus.done), 32'd0);
      check("rst_mid_result", bus.result, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);

      // Back-to-back with start held: the two done pulses are 34 cycles apart.
      do_op(3'd0, 32'd3,  32'd5,  32'd15,  1'b0, 1'b1);
      do_op(3'd0, 32'd11, 32'd13, 32'd143, 1'b0, 1'b0);
      if (done_hist.size() >= 2)
         check_int("b2b_spacing", done_hist[done_hist.size()-1] - done_hist[done_hist.size()-2], 34);
      else begin
         checks++;
         errors++;
         $display("FAIL b2b_spacing: got %0d done pulses, required at least 2", done_hist.size());
      end

      for (int k = 0; k < 40; k++) begin
         f   = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
         else if (sel == 3) b = 32'($urandom_range(1, 9)) | ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFF0 : 32'd0);
         do_op(f, a, b, ref_model(f, a, b), ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0));
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (40) @(negedge clk);
      check_int("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
